// File: rtl/dmem_access_ctrl.sv
// Memory-stage controller: issues one load/store to a multi-cycle data memory, returns data/error.
// Latency: store resp at issue+MEM_LAT, load resp cycle after mem_data_valid (or TIMEOUT); misaligned resp next cycle.
// Backpressure: req_ready only in IDLE, stall holds upstream; DMEM_PERF_CNT_EN adds a saturating stall_cnt.
module dmem_access_ctrl #(
    parameter int MEM_LAT = 4,
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_data_valid
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        BUSY_RD,
        BUSY_WR,
        RESP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               req_we_q, req_we_d;
    logic               mem_en_q, mem_en_d;
    logic               mem_wr_q, mem_wr_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [15:0]        mem_wdata_q, mem_wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [15:0]        resp_rdata_q, resp_rdata_d;

    assign req_ready = (state_q == IDLE);
    assign stall     = (req_valid && state_q == IDLE) ||
                       (state_q == ISSUE) || (state_q == BUSY_RD) || (state_q == BUSY_WR);

    assign mem_en     = mem_en_q;
    assign mem_wr     = mem_wr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_we_d     = req_we_q;
        mem_en_d     = 1'b0;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_we_d = req_we;
                    if (req_addr[0]) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 16'h0000;
                    end else begin
                        // Command regs load here so they are live during the ISSUE cycle.
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_wr_d    = req_we;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = req_we_q ? BUSY_WR : BUSY_RD;
            end
            BUSY_WR: begin
                // ISSUE plus (MEM_LAT-1) busy cycles puts RESP at ISSUE+MEM_LAT.
                if (cnt_q == CNT_W'(MEM_LAT - 2)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = 16'h0000;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            BUSY_RD: begin
                if (mem_data_valid) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = mem_rdata;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 16'h0000;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_we_q     <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 16'h0000;
            mem_wdata_q  <= 16'h0000;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_we_q     <= req_we_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed, table-driven bench for dmem_access_ctrl plus reset/idle corner sequences.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_data_valid;
`ifdef DMEM_PERF_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [15:0] last_addr = 16'h0000;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.MEM_LAT(4), .TIMEOUT(15)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .stall          (stall),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_data_valid (mem_data_valid)
`ifdef DMEM_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          dv_cyc;     // cycle (relative to accept T0) mem_data_valid is pulsed; 0 = never
        logic [15:0] mrdata;
        int          exp_resp;   // cycle resp_valid is expected
        logic        exp_err;
        logic [15:0] exp_rdata;
        int          exp_men;    // number of mem_en pulses
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t v, input int id);
        int resp_at;
        int men;
        resp_at = -1;
        men     = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
        mem_data_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_t0_ready", id), req_ready, 1);
        chk($sformatf("v%0d_t0_stall", id), stall, 1);
        for (int n = 1; n <= 40 && resp_at < 0; n++) begin
            @(negedge clk);
            req_valid      = 1'b0;
            mem_data_valid = (v.dv_cyc == n);
            mem_rdata      = v.mrdata;
            #1;
            if (mem_en) begin
                men++;
                chk($sformatf("v%0d_mem_en_cycle", id), n, 1);
                chk($sformatf("v%0d_mem_wr", id), mem_wr, v.we);
                chk($sformatf("v%0d_mem_addr", id), mem_addr, v.addr);
                chk($sformatf("v%0d_mem_wdata", id), mem_wdata, v.wdata);
            end
            chk($sformatf("v%0d_stall_c%0d", id, n), stall, (n < v.exp_resp));
            if (resp_valid) begin
                resp_at = n;
                chk($sformatf("v%0d_resp_err", id), resp_err, v.exp_err);
                chk($sformatf("v%0d_resp_rdata", id), resp_rdata, v.exp_rdata);
            end
        end
        chk($sformatf("v%0d_resp_cycle", id), resp_at, v.exp_resp);
        chk($sformatf("v%0d_mem_en_count", id), men, v.exp_men);
        @(negedge clk);
        mem_data_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_ready_after", id), req_ready, 1);
        chk($sformatf("v%0d_resp_pulse_end", id), resp_valid, 0);
        if (!v.addr[0]) last_addr = v.addr;
        chk($sformatf("v%0d_mem_addr_hold", id), mem_addr, last_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        //          we    addr      wdata     dv  mrdata    resp err rdata    men
        vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 0,  16'h0000, 5,   0,  16'h0000, 1};
        vecs[1] = '{1'b0, 16'h0022, 16'h0000, 4,  16'h1234, 5,   0,  16'h1234, 1};
        vecs[2] = '{1'b0, 16'h0013, 16'h0000, 0,  16'h0000, 1,   1,  16'h0000, 0};
        vecs[3] = '{1'b1, 16'h0101, 16'hCAFE, 0,  16'h0000, 1,   1,  16'h0000, 0};
        vecs[4] = '{1'b0, 16'h0100, 16'h0000, 2,  16'hA5A5, 3,   0,  16'hA5A5, 1};
        vecs[5] = '{1'b0, 16'h0200, 16'h0000, 0,  16'h0000, 17,  1,  16'h0000, 1};
        vecs[6] = '{1'b0, 16'h0300, 16'h0000, 16, 16'h7E57, 17,  0,  16'h7E57, 1};
        vecs[7] = '{1'b0, 16'h0400, 16'h0000, 17, 16'h9999, 17,  1,  16'h0000, 1};
        vecs[8] = '{1'b1, 16'hFFFE, 16'h0001, 0,  16'h0000, 5,   0,  16'h0000, 1};

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        mem_rdata = '0; mem_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_stall", stall, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
`ifdef DMEM_PERF_CNT_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif

        // Stray mem_data_valid while idle must not produce a response.
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            mem_data_valid = 1'b1; mem_rdata = 16'hDEAD;
            #1;
            chk($sformatf("idle_dv_resp_c%0d", n), resp_valid, 0);
        end
        @(negedge clk);
        mem_data_valid = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_txn(vecs[i], i);
`ifdef DMEM_PERF_CNT_EN
            if (i == 1) chk("stall_cnt_store_load", stall_cnt, 10);
`endif
        end

        // Reset in the middle of a read abandons it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040; req_wdata = 16'h5555;
        #1;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("mid_rst_issue", mem_en, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_wr", mem_wr, 0);
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_mem_wdata", mem_wdata, 0);
        chk("mid_rst_resp_valid", resp_valid, 0);
        chk("mid_rst_resp_err", resp_err, 0);
        chk("mid_rst_resp_rdata", resp_rdata, 0);
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_ready", req_ready, 1);
`ifdef DMEM_PERF_CNT_EN
        chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
        for (int n = 5; n <= 10; n++) begin
            @(negedge clk);
            mem_data_valid = (n == 6); mem_rdata = 16'h4321;
            #1;
            chk($sformatf("late_dv_resp_c%0d", n), resp_valid, 0);
            chk($sformatf("late_dv_stall_c%0d", n), stall, 0);
        end
        mem_data_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
